// File: rtl/regs_arbiter_if.sv
// Requester-side bus of the register-file arbiter: two independent requesters,
// A and B. Each one issues a command, then sees a grant pulse and a done pulse.
interface regs_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 4
) ();
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_ra1;
  logic [AW-1:0] a_ra2;
  logic [DW-1:0] a_wd;
  logic          a_gnt;
  logic          a_done;
  logic [DW-1:0] a_rd1;
  logic [DW-1:0] a_rd2;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_ra1;
  logic [AW-1:0] b_ra2;
  logic [DW-1:0] b_wd;
  logic          b_gnt;
  logic          b_done;
  logic [DW-1:0] b_rd1;
  logic [DW-1:0] b_rd2;

  modport master (
    output a_req, a_we, a_ra1, a_ra2, a_wd,
    input  a_gnt, a_done, a_rd1, a_rd2,
    output b_req, b_we, b_ra1, b_ra2, b_wd,
    input  b_gnt, b_done, b_rd1, b_rd2
  );

  modport slave (
    input  a_req, a_we, a_ra1, a_ra2, a_wd,
    output a_gnt, a_done, a_rd1, a_rd2,
    input  b_req, b_we, b_ra1, b_ra2, b_wd,
    output b_gnt, b_done, b_rd1, b_rd2
  );
endinterface

// File: rtl/regs_arbiter.sv
// Two-requester round-robin arbiter in front of a single-write-port register file.
// Each operation takes IDLE -> ISSUE -> RESP, so one operation completes every 3 cycles.
// A clear request outranks both requesters and uses a one-cycle CLEAR state.
module regs_arbiter #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          clr_done,
  regs_arbiter_if.slave bus,
  output logic          rf_rst,
  output logic          rf_we,
  output logic [AW-1:0] rf_i1,
  output logic [AW-1:0] rf_i2,
  output logic [DW-1:0] rf_y,
  input  logic [DW-1:0] rf_x1,
  input  logic [DW-1:0] rf_x2
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP, CLEAR} state_t;

  state_t        state_q, state_d;
  logic          take, sel_a;
  logic          owner_a_q, last_b_q, we_q;
  logic [DW-1:0] a_rd1_q, a_rd2_q, b_rd1_q, b_rd2_q;

  // Next-state logic. The winner is chosen only in IDLE. A lone request wins.
  // On a tie, the requester that was not served last wins.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    sel_a   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
        end else if (bus.a_req || bus.b_req) begin
          state_d = ISSUE;
          take    = 1'b1;
          sel_a   = bus.a_req && (!bus.b_req || last_b_q);
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation or clear in progress
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Latch the winning command and drive the file address/data. These hold until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_a_q <= 1'b0;
      last_b_q  <= 1'b1;
      we_q      <= 1'b0;
      rf_i1     <= '0;
      rf_i2     <= '0;
      rf_y      <= '0;
    end else if (take) begin
      owner_a_q <= sel_a;
      last_b_q  <= !sel_a;
      we_q      <= sel_a ? bus.a_we  : bus.b_we;
      rf_i1     <= sel_a ? bus.a_ra1 : bus.b_ra1;
      rf_i2     <= sel_a ? bus.a_ra2 : bus.b_ra2;
      rf_y      <= sel_a ? bus.a_wd  : bus.b_wd;
    end
  end

  // Capture the file read data at the end of ISSUE into the owner's result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rd1_q <= '0;
      a_rd2_q <= '0;
      b_rd1_q <= '0;
      b_rd2_q <= '0;
    end else if (state_q == ISSUE && !we_q) begin
      if (owner_a_q) begin
        a_rd1_q <= rf_x1;
        a_rd2_q <= rf_x2;
      end else begin
        b_rd1_q <= rf_x1;
        b_rd2_q <= rf_x2;
      end
    end
  end

  assign bus.a_gnt  = (state_q == ISSUE) &&  owner_a_q;
  assign bus.b_gnt  = (state_q == ISSUE) && !owner_a_q;
  assign bus.a_done = (state_q == RESP)  &&  owner_a_q;
  assign bus.b_done = (state_q == RESP)  && !owner_a_q;
  assign bus.a_rd1  = a_rd1_q;
  assign bus.a_rd2  = a_rd2_q;
  assign bus.b_rd1  = b_rd1_q;
  assign bus.b_rd2  = b_rd2_q;
  assign rf_we      = (state_q == ISSUE) && we_q;
  assign rf_rst     = (state_q == CLEAR);
  assign clr_done   = (state_q == CLEAR);
endmodule
